down_sampler: RTL and testbench

DOWN_SAMPLER -- requirements
Module: down_sampler

---
 rtl/down_sampler_pkg.sv | 23 ++
 rtl/down_line_buffer.sv | 30 +++
 rtl/down_sampler.sv | 166 ++++++++++++++++
 tb/tb_down_sampler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/down_sampler_pkg.sv
// Shared constants, FSM encoding and the rounding 2x2 average helper
// for the down-sampler and its line buffer.
package down_sampler_pkg;

   localparam int PIX_W    = 8;
   localparam int DEF_IN_W = 800;
   localparam int DEF_IN_H = 600;

   typedef enum logic {
      ST_EVEN = 1'b0,
      ST_ODD  = 1'b1
   } state_t;

   // Sum of two horizontal pair sums plus rounding, kept 10 bits wide so
   // an all-255 block cannot wrap before the divide by four.
   function automatic logic [PIX_W-1:0] box_avg(input logic [PIX_W:0] hsum,
                                                input logic [PIX_W:0] stored);
      logic [PIX_W+1:0] total;
      total = {1'b0, hsum} + {1'b0, stored} + 10'd2;
      return total[PIX_W+1:2];
   endfunction

endpackage

// File: rtl/down_line_buffer.sv
// One-row store of horizontal pair sums: single write port, single read
// port with a registered read that holds its value until the next read.
module down_line_buffer
   import down_sampler_pkg::*;
#(
   parameter int DEPTH = DEF_IN_W / 2,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [PIX_W:0]  wr_data,
   input  logic            rd_req,
   input  logic [AW-1:0]   rd_addr,
   output logic [PIX_W:0]  rd_data
);

   logic [PIX_W:0] mem [DEPTH];

   // No reset: every location is rewritten by the even row before use.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_req) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/down_sampler.sv
// 2x2 box-average down-sampler: pulls raster pixels from an upstream FIFO
// and delivers IN_W/2 x IN_H/2 rounded averages through a 2-entry buffer.
module down_sampler
   import down_sampler_pkg::*;
#(
   parameter int IN_W = DEF_IN_W,
   parameter int IN_H = DEF_IN_H
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] din,
   input  logic             in_valid,
   input  logic             in_empty,
   output logic             rd_en,
   output logic [PIX_W-1:0] dout,
   output logic             valid,
   input  logic             rd_en_down,
   output logic             frame_done
);

   localparam int CW = $clog2(IN_W);
   localparam int RW = $clog2(IN_H);
   localparam int AW = CW - 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

   state_t           state_r;
   state_t           state_nxt;
   logic [CW-1:0]    col_r;
   logic [RW-1:0]    row_r;
   logic [PIX_W-1:0] pair_r;
   logic             armed_r;
   logic             rd_prev_r;
   logic             frame_done_r;

   logic [PIX_W-1:0] fifo_mem_r [2];
   logic             wr_ptr_r;
   logic             rd_ptr_r;
   logic [1:0]       occ_r;

   logic             accept_s;
   logic             col_odd_s;
   logic             last_col_s;
   logic [PIX_W:0]   hsum_s;
   logic [PIX_W:0]   lb_q_s;
   logic             lb_wr_s;
   logic             lb_rd_s;
   logic [AW-1:0]    lb_addr_s;
   logic             push_s;
   logic             pop_s;
   logic [PIX_W-1:0] avg_s;

   // armed_r is low for one cycle after reset so a read issued before the
   // reset cannot leak its pixel into the new frame.
   assign accept_s   = in_valid && armed_r;
   assign col_odd_s  = col_r[0];
   assign last_col_s = (col_r == COL_LAST);
   assign hsum_s     = {1'b0, pair_r} + {1'b0, din};
   assign lb_addr_s  = col_r[CW-1:1];
   assign lb_wr_s    = accept_s && (state_r == ST_EVEN) && col_odd_s;
   assign lb_rd_s    = accept_s && (state_r == ST_ODD) && !col_odd_s;
   assign push_s     = accept_s && (state_r == ST_ODD) && col_odd_s;
   assign avg_s      = box_avg(hsum_s, lb_q_s);

   assign pop_s      = (occ_r != 2'd0) && rd_en_down;
   assign valid      = (occ_r != 2'd0);
   assign dout       = fifo_mem_r[rd_ptr_r];
   assign frame_done = frame_done_r;

   // Reads in flight are counted so the 2-entry buffer can never overflow.
   assign rd_en = armed_r && !rst && !in_empty &&
                  (({1'b0, occ_r} + {2'b00, rd_prev_r}) < 3'd2);

   down_line_buffer #(
      .DEPTH (IN_W / 2),
      .AW    (AW)
   ) u_line_buffer (
      .clk     (clk),
      .wr_en   (lb_wr_s),
      .wr_addr (lb_addr_s),
      .wr_data (hsum_s),
      .rd_req  (lb_rd_s),
      .rd_addr (lb_addr_s),
      .rd_data (lb_q_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_EVEN;
      end else begin
         state_r <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_r;
      case (state_r)
         ST_EVEN: begin
            if (accept_s && last_col_s) begin
               state_nxt = ST_ODD;
            end else begin
               state_nxt = ST_EVEN;
            end
         end
         ST_ODD: begin
            if (accept_s && last_col_s) begin
               state_nxt = ST_EVEN;
            end else begin
               state_nxt = ST_ODD;
            end
         end
         default: state_nxt = ST_EVEN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_r        <= '0;
         row_r        <= '0;
         pair_r       <= '0;
         armed_r      <= 1'b0;
         rd_prev_r    <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         armed_r      <= 1'b1;
         rd_prev_r    <= rd_en;
         frame_done_r <= push_s && (row_r == ROW_LAST) && last_col_s;
         if (accept_s) begin
            if (!col_odd_s) begin
               pair_r <= din;
            end
            if (last_col_s) begin
               col_r <= '0;
               row_r <= (row_r == ROW_LAST) ? '0 : row_r + 1'b1;
            end else begin
               col_r <= col_r + 1'b1;
            end
         end
      end
   end

   // Output buffer: simultaneous push and pop leave occupancy unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_mem_r[0] <= '0;
         fifo_mem_r[1] <= '0;
         wr_ptr_r      <= 1'b0;
         rd_ptr_r      <= 1'b0;
         occ_r         <= 2'd0;
      end else begin
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= avg_s;
            wr_ptr_r             <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   occ_r <= occ_r + 2'd1;
            2'b01:   occ_r <= occ_r - 2'd1;
            default: occ_r <= occ_r;
         endcase
      end
   end

endmodule

// File: tb/tb_down_sampler.sv
// Randomized bench for down_sampler: upstream FIFO model, golden 2x2-average
// queue, stall, boundary-pattern and mid-frame reset scenarios.
module tb_down_sampler;

   localparam int W     = 16;
   localparam int H     = 8;
   localparam int NPIX  = W * H;
   localparam int TOTAL = (W / 2) * (H / 2);

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic       in_valid;
   logic       in_empty;
   logic       rd_en;
   logic [7:0] dout;
   logic       valid;
   logic       rd_en_down;
   logic       frame_done;

   int checks;
   int errors;
   int img [H][W];
   int exp_q [$];
   int src_idx;
   int got;
   int done_cnt;
   int gap_pct;
   int stall_pct;
   int first_dout;
   bit stall_on;
   bit hold_ok;
   logic [7:0] held;

   down_sampler #(.IN_W(W), .IN_H(H)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .in_valid   (in_valid),
      .in_empty   (in_empty),
      .rd_en      (rd_en),
      .dout       (dout),
      .valid      (valid),
      .rd_en_down (rd_en_down),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic load_frame(input int kind, input int val);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            img[r][c] = (kind == 0) ? val : int'($urandom_range(255));
         end
      end
      if (kind == 2) begin
         img[0][0] = 10; img[0][1] = 11; img[1][0] = 12; img[1][1] = 14;
      end
      exp_q.delete();
      for (int r = 0; r < H / 2; r++) begin
         for (int c = 0; c < W / 2; c++) begin
            exp_q.push_back((img[2*r][2*c] + img[2*r][2*c+1] +
                             img[2*r+1][2*c] + img[2*r+1][2*c+1] + 2) / 4);
         end
      end
      src_idx    = 0;
      got        = 0;
      done_cnt   = 0;
      first_dout = -1;
   endtask

   // One clock: observe at the falling edge, drive new inputs after the rise.
   task automatic cycle();
      bit rd_acc;
      int e;
      @(negedge clk);
      if (frame_done) begin
         done_cnt++;
         checks++;
         assert (exp_q.size() >= 1 && exp_q.size() <= 2) else begin
            errors++;
            $error("FAIL frame_done_timing pending=%0d required 1..2", exp_q.size());
         end
      end
      if (valid && rd_en_down) begin
         checks++;
         if (exp_q.size() == 0) begin
            assert (0) else begin
               errors++;
               $error("FAIL extra_pixel got %0d required none", dout);
            end
         end else begin
            e = exp_q.pop_front();
            if (got == 0) first_dout = int'(dout);
            got++;
            assert (dout === 8'(e)) else begin
               errors++;
               $error("FAIL pixel%0d got %0d required %0d", got - 1, dout, e);
            end
         end
      end
      if (stall_on) begin
         if (hold_ok) begin
            checks++;
            assert (valid === 1'b1 && dout === held) else begin
               errors++;
               $error("FAIL stall_hold got v=%0b d=%0d required v=1 d=%0d", valid, dout, held);
            end
         end
         if (valid) begin
            hold_ok = 1'b1;
            held    = dout;
         end
      end
      rd_acc = rd_en;
      @(posedge clk);
      #1;
      if (rd_acc) begin
         din      = 8'(img[src_idx / W][src_idx % W]);
         in_valid = 1'b1;
         src_idx++;
      end else begin
         in_valid = 1'b0;
      end
      in_empty   = (src_idx >= NPIX) || (int'($urandom_range(99)) < gap_pct);
      rd_en_down = !stall_on && (int'($urandom_range(99)) >= stall_pct);
   endtask

   task automatic run_frame(input int budget);
      int n;
      n = 0;
      while ((got < TOTAL || done_cnt == 0) && n < budget) begin
         cycle();
         n++;
      end
      checks++;
      assert (n < budget) else begin
         errors++;
         $error("FAIL frame_timeout got %0d pixels required %0d", got, TOTAL);
      end
      for (int i = 0; i < 6; i++) cycle();
      checks++;
      assert (got === TOTAL) else begin
         errors++;
         $error("FAIL pixel_count got %0d required %0d", got, TOTAL);
      end
      checks++;
      assert (done_cnt === 1) else begin
         errors++;
         $error("FAIL frame_done_count got %0d required 1", done_cnt);
      end
      checks++;
      assert (valid === 1'b0) else begin
         errors++;
         $error("FAIL idle_valid got %0b required 0", valid);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      checks++;
      assert (valid === 1'b0 && rd_en === 1'b0 && dout === 8'd0 && frame_done === 1'b0) else begin
         errors++;
         $error("FAIL %s got v=%0b rd=%0b d=%0d fd=%0b required 0/0/0/0",
                tag, valid, rd_en, dout, frame_done);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      stall_on   = 1'b0;
      hold_ok    = 1'b0;
      held       = 8'd0;
      gap_pct    = 0;
      stall_pct  = 0;
      rst        = 1'b1;
      din        = 8'd0;
      in_valid   = 1'b0;
      in_empty   = 1'b1;
      rd_en_down = 1'b0;
      load_frame(0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Constant 100 frame, consumer always ready.
      load_frame(0, 100);
      run_frame(4000);

      // Corner block 10,11,12,14 with random gaps.
      gap_pct   = 25;
      stall_pct = 20;
      load_frame(2, 0);
      run_frame(6000);
      checks++;
      assert (first_dout === 12) else begin
         errors++;
         $error("FAIL first_avg got %0d required 12", first_dout);
      end

      // Saturation and zero extremes.
      load_frame(0, 255);
      run_frame(6000);
      load_frame(0, 0);
      run_frame(6000);

      // Random data under heavy back-pressure and gaps, twice.
      for (int f = 0; f < 2; f++) begin
         gap_pct   = 40;
         stall_pct = 50;
         load_frame(1, 0);
         run_frame(10000);
      end

      // Consumer stalled for 50 cycles mid-frame.
      gap_pct   = 0;
      stall_pct = 0;
      load_frame(1, 0);
      repeat (30) cycle();
      stall_on = 1'b1;
      hold_ok  = 1'b0;
      rd_en_down = 1'b0;
      repeat (50) cycle();
      checks++;
      assert (valid === 1'b1 && rd_en === 1'b0) else begin
         errors++;
         $error("FAIL stall_end got v=%0b rd=%0b required v=1 rd=0", valid, rd_en);
      end
      stall_on = 1'b0;
      run_frame(6000);

      // Reset in the middle of a frame, stray in_valid afterwards, new frame.
      gap_pct   = 10;
      stall_pct = 30;
      load_frame(1, 0);
      repeat (70) cycle();
      rst      = 1'b1;
      in_empty = 1'b0;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b1;
      din      = 8'hAA;
      in_empty = 1'b0;
      check_reset_outputs("after_midframe_reset");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_empty = 1'b1;
      gap_pct   = 0;
      stall_pct = 0;
      load_frame(0, 100);
      run_frame(4000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
